// File: rtl/mem_arbiter_pkg.sv
// Shared configuration for the memory arbiter.
// Contents:
//   - FSM state encodings (kept as plain 3-bit constants for legacy tools)
//   - default starvation limit and IO address selector
//   - read/write and access-length codes used on the mc_* interface
//   - grant_t: result of the combinational grant decision
//   - io_blocked(): tells whether an LS store cannot go out because the
//     IO write buffer is full
package mem_arbiter_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_BUSY_IF = 3'd1;
    localparam logic [2:0] ST_BUSY_LS = 3'd2;
    localparam logic [2:0] ST_DROP    = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    localparam int         STARVE_LIMIT_DEF = 4;
    localparam logic [1:0] IO_SEL_DEF       = 2'b11;

    localparam logic       MEM_READ  = 1'b0;
    localparam logic       MEM_WRITE = 1'b1;

    localparam logic [2:0] LEN_BYTE = 3'd1;
    localparam logic [2:0] LEN_HALF = 3'd2;
    localparam logic [2:0] LEN_WORD = 3'd4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_LS   = 2'd2
    } grant_t;

    // A store to the IO window is held back while the IO buffer is full.
    function automatic logic io_blocked(input logic       we,
                                        input logic [1:0] addr_sel,
                                        input logic [1:0] io_sel,
                                        input logic       buffer_full);
        return we && (addr_sel == io_sel) && buffer_full;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch (IF) and load/store (LS) share
// one byte-serial memory controller.
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   rdy                 global enable; low freezes every register
//   flush               branch mispredict, cancels an instruction fetch
//   io_buffer_full      IO write path cannot take a store
//   if_req/if_addr      fetch request; if_ack/if_data response
//   ls_req/ls_we/ls_len/ls_addr/ls_wdata   load/store request;
//   ls_ack/ls_rdata     load/store response
//   mc_en/mc_we/mc_len/mc_addr/mc_wdata    request to memory controller
//   mc_done/mc_rdata    completion and read data from memory controller
// LS has priority; a starvation counter forces an IF grant after
// STARVE_LIMIT consecutive LS grants made while IF was waiting.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int         STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter logic [1:0] IO_SEL       = IO_SEL_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [2:0]  ls_len,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ack,
    output logic [31:0] ls_rdata,
    output logic        mc_en,
    output logic        mc_we,
    output logic [2:0]  mc_len,
    output logic [31:0] mc_addr,
    output logic [31:0] mc_wdata,
    input  logic        mc_done,
    input  logic [31:0] mc_rdata
);

    localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [2:0]       state_r;
    logic [CNT_W-1:0] starve_cnt_r;
    grant_t           grant_s;
    logic             ls_ok_s;
    logic             if_ok_s;

    // Grant decision for the current IDLE cycle.
    always_comb begin
        grant_s = GNT_NONE;
        ls_ok_s = ls_req && !io_blocked(ls_we, ls_addr[17:16], IO_SEL, io_buffer_full);
        if_ok_s = if_req && !flush;
        if (if_ok_s && (starve_cnt_r == LIMIT_C)) begin
            grant_s = GNT_IF;
        end else if (ls_ok_s) begin
            grant_s = GNT_LS;
        end else if (if_ok_s) begin
            grant_s = GNT_IF;
        end else begin
            grant_s = GNT_NONE;
        end
    end

    // Arbiter FSM, starvation counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            starve_cnt_r <= '0;
            mc_en        <= 1'b0;
            mc_we        <= 1'b0;
            mc_len       <= 3'd0;
            mc_addr      <= 32'd0;
            mc_wdata     <= 32'd0;
            if_ack       <= 1'b0;
            if_data      <= 32'd0;
            ls_ack       <= 1'b0;
            ls_rdata     <= 32'd0;
        end else if (rdy) begin
            case (state_r)
                ST_IDLE: begin
                    case (grant_s)
                        GNT_IF: begin
                            state_r      <= ST_BUSY_IF;
                            starve_cnt_r <= '0;
                            mc_en        <= 1'b1;
                            mc_we        <= MEM_READ;
                            mc_len       <= LEN_WORD;
                            mc_addr      <= if_addr;
                            mc_wdata     <= 32'd0;
                        end
                        GNT_LS: begin
                            state_r  <= ST_BUSY_LS;
                            mc_en    <= 1'b1;
                            mc_we    <= ls_we;
                            mc_len   <= ls_len;
                            mc_addr  <= ls_addr;
                            mc_wdata <= ls_wdata;
                            // Only LS grants that overtake a waiting fetch count.
                            if (!if_req) begin
                                starve_cnt_r <= '0;
                            end else if (starve_cnt_r != LIMIT_C) begin
                                starve_cnt_r <= starve_cnt_r + CNT_W'(1);
                            end
                        end
                        default: begin
                            if (!if_req) begin
                                starve_cnt_r <= '0;
                            end
                        end
                    endcase
                end
                ST_BUSY_IF: begin
                    // The controller cannot be aborted, so a flushed fetch
                    // still runs to mc_done; its data is simply discarded.
                    if (flush) begin
                        if (mc_done) begin
                            state_r <= ST_IDLE;
                            mc_en   <= 1'b0;
                        end else begin
                            state_r <= ST_DROP;
                        end
                    end else if (mc_done) begin
                        state_r <= ST_RESP;
                        mc_en   <= 1'b0;
                        if_ack  <= 1'b1;
                        if_data <= mc_rdata;
                    end
                end
                ST_BUSY_LS: begin
                    if (mc_done) begin
                        state_r  <= ST_RESP;
                        mc_en    <= 1'b0;
                        ls_ack   <= 1'b1;
                        ls_rdata <= mc_rdata;
                    end
                end
                ST_DROP: begin
                    if (mc_done) begin
                        state_r <= ST_IDLE;
                        mc_en   <= 1'b0;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    if_ack  <= 1'b0;
                    ls_ack  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    mc_en   <= 1'b0;
                    if_ack  <= 1'b0;
                    ls_ack  <= 1'b0;
                end
            endcase
        end
    end

endmodule
